mips32_prog_loader: RTL

Instruction encoder and program loader for the pipelined MIPS32 core: accepts decoded instruction fields over a valid/ready stream, packs them into 32-bit machine words using the core's ISA encoding, and writes them to sequential instruction-memory addresses. It is the writer/encoder end of the instruction format that the core's IF/ID stages read and decode. It sits between a host/test source and the core's memory write port, and holds the write port only while a load is in progress.

---
 rtl/mips32_prog_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mips32_prog_loader.sv
// MIPS32 program loader: packs decoded instruction fields into machine
// words and streams them into sequential instruction-memory addresses.
module mips32_prog_loader #(
  parameter int AW        = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [AW:0] LP_MAX = (AW+1)'(MAX_WORDS);

  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_maddr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          r_done;
  logic          r_err;
  logic [AW:0]   r_count;

  logic          w_is_rr;
  logic          w_is_rm;
  logic          w_is_br;
  logic          w_is_hlt;
  logic          w_ok;
  logic [31:0]   w_word;
  logic [AW:0]   w_cnt_nx;
  logic          w_accept;

  assign w_is_rr  = (in_op <= OP_MUL);
  assign w_is_rm  = (in_op >= OP_LW) && (in_op <= OP_SLTI);
  assign w_is_br  = (in_op == OP_BNEQZ) || (in_op == OP_BEQZ);
  assign w_is_hlt = (in_op == OP_HLT);
  assign w_cnt_nx = r_count + 1'b1;
  assign w_accept = in_valid && (r_state == S_LOAD);

  // Encode the presented fields; unused fields are forced to zero.
  always_comb begin
    w_ok   = 1'b0;
    w_word = 32'h0;
    unique case (1'b1)
      w_is_rr: begin
        w_ok   = 1'b1;
        w_word = {in_op, in_rs, in_rt, in_rd, 11'b0};
      end
      w_is_rm: begin
        w_ok   = 1'b1;
        w_word = {in_op, in_rs, in_rt, in_imm};
      end
      w_is_br: begin
        w_ok   = 1'b1;
        w_word = {in_op, in_rs, 5'b0, in_imm};
      end
      w_is_hlt: begin
        w_ok   = 1'b1;
        w_word = 32'hfc000000;
      end
      default: begin
        w_ok   = 1'b0;
        w_word = 32'h0;
      end
    endcase
  end

  // Load FSM, write port registers and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_maddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_state == S_LOAD) begin
        if (w_accept) begin
          if (w_ok) begin
            r_we    <= 1'b1;
            r_maddr <= r_ptr;
            r_wdata <= w_word;
            r_ptr   <= r_ptr + 1'b1;
            r_count <= w_cnt_nx;
            if (w_is_hlt) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_cnt_nx == LP_MAX) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end else begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end
      end else if (start) begin
        r_state <= S_LOAD;
        r_ptr   <= base_addr;
        r_count <= '0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state == S_LOAD);
  assign mem_we    = r_we;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_wdata;
  assign done      = r_done;
  assign err       = r_err;
  assign count     = r_count;

endmodule
